// File: rtl/lsu_pkg.sv
// Shared instruction definitions for the load/store unit: opcodes,
// funct3 access codes, register widths and FSM state encodings.
package lsu_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;

   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_ST = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef logic [1:0] lsu_state_t;
   localparam lsu_state_t ST_IDLE   = 2'd0;
   localparam lsu_state_t ST_ACCESS = 2'd1;
   localparam lsu_state_t ST_RESP   = 2'd2;

   // Loads accept B/H/W/BU/HU, stores accept B/H/W; everything else is illegal.
   function automatic logic is_legal(input logic [6:0] op, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      if (op == OP_LD)
         ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
              (f3 == F3_BU) || (f3 == F3_HU);
      else if (op == OP_ST)
         ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return ok;
   endfunction

   // Size is carried in funct3[1:0]; bytes can never be misaligned.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      logic mis;
      case (f3[1:0])
         2'b01:   mis = a[0];
         2'b10:   mis = (a != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for the LSU: byte enables, store data replication and
// load data lane selection with sign/zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]      funct3,
   input  logic            is_store,
   input  logic [1:0]      lane,
   input  logic [XLEN-1:0] wdata,
   input  logic [XLEN-1:0] rdata,
   output logic [3:0]      be,
   output logic [XLEN-1:0] wdata_rep,
   output logic [XLEN-1:0] ld_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte/halfword out of the returned word
   always_comb begin
      byte_sel = rdata[{lane, 3'b000} +: 8];
      half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
   end

   // Store enables/replication and load extension
   always_comb begin
      be        = 4'b1111;
      wdata_rep = wdata;
      ld_data   = rdata;
      if (is_store) begin
         case (funct3)
            F3_B: begin
               be        = 4'b0001 << lane;
               wdata_rep = {4{wdata[7:0]}};
            end
            F3_H: begin
               be        = lane[1] ? 4'b1100 : 4'b0011;
               wdata_rep = {2{wdata[15:0]}};
            end
            default: ;
         endcase
      end
      case (funct3)
         F3_B:    ld_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         F3_H:    ld_data = {{(XLEN-16){half_sel[15]}}, half_sel};
         F3_BU:   ld_data = {{(XLEN-8){1'b0}}, byte_sel};
         F3_HU:   ld_data = {{(XLEN-16){1'b0}}, half_sel};
         default: ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one load/store from EX, performs a single
// word-aligned memory access with an ack timeout, and returns a one-cycle
// completion pulse with optional register writeback.
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [6:0]        req_op,
   input  logic [2:0]        req_funct3,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  logic [REG_AW-1:0] req_rd,
   output logic              mem_req,
   output logic              mem_we,
   output logic [XLEN-1:0]   mem_addr,
   output logic [3:0]        mem_be,
   output logic [XLEN-1:0]   mem_wdata,
   input  logic              mem_ack,
   input  logic [XLEN-1:0]   mem_rdata,
   output logic              rsp_valid,
   output logic              rsp_we,
   output logic [REG_AW-1:0] rsp_rd,
   output logic [XLEN-1:0]   rsp_data,
   output logic              misalign,
   output logic              bus_err,
   output logic              stall
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   lsu_state_t        state;
   logic [6:0]        op_q;
   logic [2:0]        f3_q;
   logic [XLEN-1:0]   addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [REG_AW-1:0] rd_q;
   logic              legal_q;
   logic              mis_q;
   logic              err_q;
   logic [XLEN-1:0]   rdata_q;
   logic [7:0]        cnt;

   logic              req_legal;
   logic              req_mis;
   logic              in_access;
   logic              in_resp;
   logic              is_store;
   logic [3:0]        be;
   logic [XLEN-1:0]   wdata_rep;
   logic [XLEN-1:0]   ld_data;

   // Classify the incoming request
   always_comb begin
      req_legal = is_legal(req_op, req_funct3);
      req_mis   = req_legal && is_misaligned(req_funct3, req_addr[1:0]);
   end

   // Request capture, access/timeout sequencing and response handoff
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         op_q    <= '0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         legal_q <= 1'b0;
         mis_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op;
                  f3_q    <= req_funct3;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  rd_q    <= req_rd;
                  legal_q <= req_legal;
                  mis_q   <= req_mis;
                  err_q   <= 1'b0;
                  cnt     <= '0;
                  state   <= (req_legal && !req_mis) ? ST_ACCESS : ST_RESP;
               end
            end
            ST_ACCESS: begin
               if (mem_ack) begin
                  rdata_q <= mem_rdata;
                  state   <= ST_RESP;
               end else if (cnt == TO_LAST) begin
                  err_q <= 1'b1;
                  state <= ST_RESP;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            ST_RESP: begin
               cnt   <= '0;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign in_access = (state == ST_ACCESS);
   assign in_resp   = (state == ST_RESP);
   assign is_store  = (op_q == OP_ST);

   lsu_align u_align (
      .funct3    (f3_q),
      .is_store  (is_store),
      .lane      (addr_q[1:0]),
      .wdata     (wdata_q),
      .rdata     (rdata_q),
      .be        (be),
      .wdata_rep (wdata_rep),
      .ld_data   (ld_data)
   );

   // Bus and response outputs are zero outside their owning state
   always_comb begin
      req_ready = (state == ST_IDLE);
      mem_req   = in_access;
      mem_we    = in_access && is_store;
      mem_addr  = in_access ? {addr_q[XLEN-1:2], 2'b00} : '0;
      mem_be    = in_access ? be : '0;
      mem_wdata = in_access ? wdata_rep : '0;
      rsp_valid = in_resp;
      rsp_we    = in_resp && (op_q == OP_LD) && legal_q && !mis_q && !err_q;
      rsp_rd    = in_resp ? rd_q : '0;
      rsp_data  = rsp_we ? ld_data : '0;
      misalign  = in_resp && mis_q;
      bus_err   = in_resp && err_q;
      // rst_n gating keeps stall low while reset is held, even with req_valid up
      stall     = rst_n && ((state != ST_IDLE) || (req_valid && req_legal));
   end

endmodule
